pulse_meter: RTL
================

# pulse_meter

Synthesizable measurement block: the receive-side counterpart of the team's phase/ton/toff clock-pattern generator. It samples an asynchronous pulse train on `sig_in` against the system clock. It reports the phase from a start request to the first rising edge, plus the high time and low time of each period, all in clock cycles. It sits in the self-check path of the clock/waveform benches and in on-chip duty-cycle monitors.

## Interface
Parameters:
- `CW`, 16, width of every counter and result field.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: begin a measurement; sampled only in IDLE.
- `cont`, in, 1: continuous mode; sampled together with `start`.
- `abort`, in, 1: return to IDLE on the next edge; ignored in IDLE.
- `sig_in`, in, 1: asynchronous waveform under test.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `meas_valid`, out, 1: one-cycle pulse; result fields updated on the same edge.
- `phase_cnt`, out, CW: cycles from start acceptance to the first detected rise.
- `ton_cnt`, out, CW: high time in cycles.
- `toff_cnt`, out, CW: low time in cycles.
- `timeout`, out, 1: one-cycle pulse when a counter saturates.

## Operation
- `sig_in` passes through a 2-flop synchronizer (s1→s2), then a delay flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - s1, s2 and s3 reset to 0.
- Single counter `cnt` (CW bits). FSM states: IDLE, WAIT_RISE, HIGH, LOW.
- IDLE, with `start`=1 and `abort`=0:
  - cnt←1, latch `cont`, go to WAIT_RISE.
  - A rise detected in that same cycle is ignored.
- WAIT_RISE:
  - On rise: phase_cnt←cnt, cnt←1, go to HIGH.
  - Otherwise cnt←cnt+1.
- HIGH:
  - On fall: ton_cnt←cnt, cnt←1, go to LOW.
  - Otherwise cnt←cnt+1.
- LOW:
  - On rise: toff_cnt←cnt, meas_valid←1, cnt←1.
  - Next state is HIGH if latched `cont`=1, else IDLE.
  - Otherwise cnt←cnt+1.
- Continuous mode:
  - phase_cnt keeps its first value.
  - ton_cnt and toff_cnt update on each period; ton_cnt updates at the fall, one meas_valid per full period.
- Saturation: if cnt = 2^CW−1 in WAIT_RISE, HIGH or LOW and the expected edge is absent that cycle:
  - pulse timeout, go to IDLE, no meas_valid.
  - Result fields are not modified.
- `abort` in any non-IDLE state: go to IDLE, no meas_valid, no timeout, result fields unchanged.
- Priority in a single cycle: abort > edge capture > saturation.
- `start` while busy is ignored.
- Result fields hold their values until overwritten; they are never cleared except by reset.

## Timing
- Reset values: state IDLE, busy 0, meas_valid 0, timeout 0, phase_cnt/ton_cnt/toff_cnt 0, cnt 0.
- busy rises on the edge that accepts `start`. It falls on the edge that enters IDLE (final meas_valid, timeout or abort).
- Synchronizer latency is 2 cycles from the first clk edge that samples `sig_in` high to the rise-detect edge. It cancels in ton/toff but is included in phase.
  - If start is accepted at edge E0 and `sig_in` is first sampled high at E_k, then phase_cnt = k+2.
- For a clock-synchronous `sig_in` high for N cycles and low for M cycles: ton_cnt=N, toff_cnt=M.
- Minimum measurable high or low time is 1 cycle. Pulses narrower than one clk period may be missed; this is a documented limitation.
- `sig_in` already high when start is accepted: the level is ignored, and measurement begins at the next detected rise.
- A `sig_in` high present at reset release appears as a rise if detected in WAIT_RISE; this is accepted behaviour.

## Test plan
- Basic one-shot:
  - Stimulus: start at E0 with cont=0; `sig_in` first sampled high at E7, held high 5 cycles, then low 5 cycles, then high again.
  - Required: phase_cnt=9, ton_cnt=5, toff_cnt=5, one meas_valid; busy drops on the same edge as meas_valid.
- Continuous asymmetric:
  - Stimulus: cont=1; `sig_in` pattern 3 high / 12 low repeated 4 periods.
  - Required: four meas_valid pulses, each with ton=3 and toff=12; phase_cnt is unchanged after the first; busy stays 1.
- Timeout:
  - Stimulus: CW=4; start with `sig_in` held at 0.
  - Required: timeout pulses with cnt=15, busy falls, meas_valid never asserts, result fields keep their prior values.
- Abort mid-HIGH:
  - Stimulus: assert abort while in HIGH.
  - Required: IDLE on the next edge, no meas_valid, no timeout, ton_cnt unchanged; a new start then measures correctly.
- Abort collisions:
  - Stimulus: abort on the same cycle as the LOW→rise capture.
  - Required: no meas_valid, toff_cnt unchanged.
  - Stimulus: start and abort together in IDLE.
  - Required: stays in IDLE.
- Async reset:
  - Stimulus: assert rst_n=0 mid-LOW, off a clk edge.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge.
  - After release: start behaves as in the basic one-shot scenario.

Source files
------------

// File: rtl/pulse_meter.sv
// Measures phase-to-first-rise, high time and low time of an asynchronous pulse
// train in system clock cycles, in one-shot or continuous mode.
module pulse_meter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic          sig_in,
    output logic          busy,
    output logic          meas_valid,
    output logic [CW-1:0] phase_cnt,
    output logic [CW-1:0] ton_cnt,
    output logic [CW-1:0] toff_cnt,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic          rise, fall, sat;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [CW-1:0] ton_q, ton_d;
    logic [CW-1:0] toff_q, toff_d;
    logic          cont_q, cont_d;
    logic          mv_q, mv_d;
    logic          to_q, to_d;

    // s1/s2 resolve metastability; s3 is the one-cycle history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    assign sat  = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            ton_q   <= '0;
            toff_q  <= '0;
            cont_q  <= 1'b0;
            mv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            ton_q   <= ton_d;
            toff_q  <= toff_d;
            cont_q  <= cont_d;
            mv_q    <= mv_d;
            to_q    <= to_d;
        end
    end

    // Priority within each active state: abort, then edge capture, then saturation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        ton_d   = ton_q;
        toff_d  = toff_q;
        cont_d  = cont_q;
        mv_d    = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cnt_d   = CNT_ONE;
                    cont_d  = cont;
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rise) begin
                    phase_d = cnt_q;
                    cnt_d   = CNT_ONE;
                    state_d = HIGH;
                end else if (sat) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (fall) begin
                    ton_d   = cnt_q;
                    cnt_d   = CNT_ONE;
                    state_d = LOW;
                end else if (sat) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rise) begin
                    toff_d  = cnt_q;
                    mv_d    = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = cont_q ? HIGH : IDLE;
                end else if (sat) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign meas_valid = mv_q;
    assign timeout    = to_q;
    assign phase_cnt  = phase_q;
    assign ton_cnt    = ton_q;
    assign toff_cnt   = toff_q;

endmodule
